// File: rtl/adder_error_monitor.sv
// adder_error_monitor: windowed error statistics of an approximate adder
// against its exact reference.
//
// Ports:
//   clk, rst_n   clock and async active-low reset
//   start        open a window (IDLE only); num_samples latched here
//   abort        close the window early, no done pulse (RUN only)
//   in_valid     sample pair present; in_ready high only in RUN
//   approx_sum   approximate result {carry,sum}, WIDTH+1 bits
//   exact_sum    exact result {carry,sum}, WIDTH+1 bits
//   busy, done   RUN indicator / one-cycle completion pulse
//   sample_count accepted handshakes this window
//   err_count    samples whose error distance is nonzero
//   sum_ed       saturating sum of error distances; ovf sticky on clamp
//   max_ed       largest error distance
//
// Optional feature macro: ERRMON_MAX_ED_EN.
// When undefined, max_ed tracking is removed and max_ed reads 0.

module adder_error_monitor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   approx_sum,
    input  logic [WIDTH:0]   exact_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] sum_ed,
    output logic [WIDTH:0]   max_ed,
    output logic             ovf
);

    // Accumulator sum is formed wide enough for either operand plus
    // one carry bit, so the clamp test never loses the overflow.
    localparam int SW = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;
    localparam logic [SW-1:0] ACC_MAX = (SW'(1) << ACC_W) - SW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] n_reg;
    logic             fire;
    logic             clr;
    logic             last;
    logic [WIDTH:0]   ed;
    logic [SW-1:0]    sum_wide;
    logic             sat;

    // A sample arriving with abort is dropped, never counted.
    always_comb begin
        fire = in_valid & in_ready & ~abort;
        last = (sample_count == n_reg - CNT_W'(1));
    end

    always_comb begin
        if (approx_sum >= exact_sum) begin
            ed = approx_sum - exact_sum;
        end else begin
            ed = exact_sum - approx_sum;
        end
        sum_wide = SW'(sum_ed) + SW'(ed);
        sat      = (sum_wide > ACC_MAX);
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    clr = 1'b1;
                    if (num_samples == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (fire && last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status flags are flops loaded from the next state so they are
    // registered outputs yet stay aligned with the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= (state_nxt == RUN);
            busy     <= (state_nxt == RUN);
            done     <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg        <= '0;
            sample_count <= '0;
            err_count    <= '0;
            sum_ed       <= '0;
            ovf          <= 1'b0;
        end else if (clr) begin
            n_reg        <= num_samples;
            sample_count <= '0;
            err_count    <= '0;
            sum_ed       <= '0;
            ovf          <= 1'b0;
        end else if (fire) begin
            sample_count <= sample_count + CNT_W'(1);
            if (ed != '0) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (sat) begin
                sum_ed <= ACC_MAX[ACC_W-1:0];
                ovf    <= 1'b1;
            end else begin
                sum_ed <= sum_wide[ACC_W-1:0];
            end
        end
    end

`ifdef ERRMON_MAX_ED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_ed <= '0;
        end else if (clr) begin
            max_ed <= '0;
        end else if (fire && (ed > max_ed)) begin
            max_ed <= ed;
        end
    end
`else
    assign max_ed = '0;
`endif

endmodule

// File: doc/adder_error_monitor.md
# adder_error_monitor

Sequential error-characterisation stage that sits directly downstream of the half/full-adder and approximate-adder datapaths. Each cycle it consumes one pair of sums: the approximate adder's result and the exact reference result for the same operands. Over a programmed window of samples it accumulates error statistics: error count, total error distance, maximum error distance and saturation. On-chip and bench characterisation of approximate adders reads these statistics instead of raw sum streams.

## Interface
Parameters:
- WIDTH, 8, operand width; sums are WIDTH+1 bits (carry included)
- CNT_W, 16, width of sample and error counters
- ACC_W, 32, width of the error-distance accumulator

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a new window; sampled only in IDLE
- abort  in  1  terminate the window without a done pulse
- num_samples  in  CNT_W  window length; latched on accepted start
- in_valid  in  1  sample pair present
- in_ready  out  1  monitor accepts a sample; high only in RUN
- approx_sum  in  WIDTH+1  approximate adder result {carry,sum}
- exact_sum  in  WIDTH+1  exact result {carry,sum}
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at window completion
- sample_count  out  CNT_W  handshakes accepted this window
- err_count  out  CNT_W  samples with approx_sum != exact_sum
- sum_ed  out  ACC_W  saturating sum of |approx_sum - exact_sum|
- max_ed  out  WIDTH+1  largest single error distance
- ovf  out  1  sticky; set when sum_ed saturates

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN:
  - Condition: start=1 and num_samples != 0.
  - Clears all statistics and ovf, and latches num_samples.
- IDLE → DONE:
  - Condition: start=1 and num_samples == 0.
  - Clears all statistics; the window is empty.
- RUN behaviour:
  - A handshake is in_valid & in_ready.
  - Error distance: ed = |approx_sum - exact_sum|, computed unsigned at WIDTH+1 bits.
  - Per handshake: sample_count +1; err_count +1 if ed != 0; sum_ed += ed, clamped to 2^ACC_W-1 with ovf set; max_ed = max(max_ed, ed).
- RUN → DONE: on the handshake where sample_count == latched num_samples-1.
- RUN → IDLE: on abort=1.
  - A handshake in the same cycle as abort is dropped and not counted.
  - Partial statistics are held; done is not pulsed.
- DONE → IDLE: unconditionally after one cycle; done=1 only in DONE.
- start is ignored in RUN and DONE. abort is ignored outside RUN.
- Statistics outputs hold their values in IDLE until the next accepted start.
- ovf is sticky within a window. Once sum_ed saturates it stays at all-ones.

## Timing
- Reset values: every output is 0 and the state is IDLE, so in_ready=0, busy=0 and done=0.
- Reset is asynchronous. Asserting it mid-window discards the window immediately with no done pulse.
- All outputs are registered.
- Statistics reflect a handshake in cycle N from cycle N+1.
- done rises in cycle N+1 after the final handshake in cycle N. The statistics then already include the final sample.
- Zero-length window: start in cycle N gives done=1 in cycle N+1 with all statistics 0.
- Back-to-back windows: start may be asserted in the cycle done=1 is high, but is only accepted in the following IDLE cycle.
- Minimum window time is num_samples + 1 cycles, assuming in_valid is held high.

## Configuration
- ERRMON_MAX_ED_EN:
  - Defined: max_ed tracking is compiled in as described above.
  - Undefined: the comparator and register are removed, and max_ed is tied to 0.
  - All other behaviour is identical either way.

## Test plan
- Reset: assert rst_n=0 mid-RUN after 2 samples → all outputs 0 immediately, FSM in IDLE, in_ready=0 on release.
- Basic window (WIDTH=8):
  - Stimulus: start, num_samples=4; pairs (approx,exact) = (10,10), (12,10), (7,10), (255,255).
  - Response: done one cycle after the 4th handshake; sample_count=4, err_count=2, sum_ed=5, max_ed=3, ovf=0.
- Zero window and gaps:
  - num_samples=0 → done in cycle after start, all stats 0, in_ready never high.
  - num_samples=3 with in_valid toggling 1,0,0,1,0,1 → done after the 3rd accepted sample; sample_count=3.
- Saturation:
  - Stimulus: ACC_W=4; num_samples=3, each sample ed=7 (e.g. (17,10)).
  - Response: sum_ed=15 after the 3rd sample, ovf=1 and held to done.
  - ovf is cleared by the next start.
- Abort:
  - Stimulus: num_samples=5; abort asserted together with the 3rd valid sample.
  - Response: FSM in IDLE, no done; sample_count=2 and the dropped sample is not counted.
  - A start in the next cycle is accepted and clears the stats.
- Macro off: with ERRMON_MAX_ED_EN undefined, rerun the basic window → identical results except max_ed=0 throughout.
